// File: rtl/ram_bus_ctrl_pkg.sv
// Shared types and helpers for the gray-addressed RAM bus controller.
package ram_bus_ctrl_pkg;

   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_ADDR_BITS = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_HOLD = 3'd3,
      ST_CLEAR   = 3'd4
   } state_t;

   function automatic logic [DEF_ADDR_BITS-1:0] bin2gray(input logic [DEF_ADDR_BITS-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/ram_bus_ctrl_if.sv
// Command and RAM-pin bundle of the controller; RAM_DATA stays a separate inout port.
interface ram_bus_ctrl_if #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 3
) ();
   import ram_bus_ctrl_pkg::*;

   // req/clr are sampled only while idle; the requester holds req until it sees
   // the one-cycle done pulse and then drops it. Commands seen while busy are ignored.
   logic                 req;
   logic                 wr;
   logic [ADDR_BITS-1:0] addr_in;
   logic [DATA_BITS-1:0] wdata;
   logic                 clr;
   logic                 busy;
   logic                 done;
   logic [DATA_BITS-1:0] rdata;
   logic                 ram_cs;
   logic                 ram_rw;
   logic [ADDR_BITS-1:0] ram_address;
   logic                 data_oe;
   state_t               state;

   modport master (
      input  req, wr, addr_in, wdata, clr,
      output busy, done, rdata, ram_cs, ram_rw, ram_address, data_oe, state
   );

   modport slave (
      output req, wr, addr_in, wdata, clr,
      input  busy, done, rdata, ram_cs, ram_rw, ram_address, data_oe, state
   );

endinterface

// File: rtl/ram_bus_ctrl_bin2gray_enc.sv
// Combinational binary-to-gray encoder.
module ram_bus_ctrl_bin2gray_enc #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/ram_bus_ctrl.sv
// Bus master for the gray-addressed RAM: turns REQ/CLR commands into timed RAM cycles.
module ram_bus_ctrl
   import ram_bus_ctrl_pkg::*;
#(
   parameter int                   DATA_BITS = DEF_DATA_BITS,
   parameter int                   ADDR_BITS = DEF_ADDR_BITS,
   parameter logic [DATA_BITS-1:0] CLR_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   ram_bus_ctrl_if.master       bus,
   inout  wire  [DATA_BITS-1:0] ram_data
);

   localparam logic [ADDR_BITS-1:0] CNT_MAX = '1;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d, cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] enc_bin, enc_gray, ram_address_q;
   logic [DATA_BITS-1:0] wdata_q, wdata_d, dout_q, dout_d, rdata_q;
   logic                 cs_q, cs_d, rw_q, rw_d, oe_q, oe_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 accept;

   assign accept = (state_q == ST_IDLE) && !bus.clr && bus.req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.clr)      state_d = ST_CLEAR;
            else if (bus.req) state_d = bus.wr ? ST_WRITE : ST_RD_ADDR;
         end
         ST_WRITE:   state_d = ST_IDLE;
         ST_RD_ADDR: state_d = ST_RD_HOLD;
         ST_RD_HOLD: state_d = ST_IDLE;
         ST_CLEAR:   if (cnt_q == CNT_MAX) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Pin values are computed from the next state so every RAM pin comes straight from a flop.
   always_comb begin
      cs_d    = (state_d != ST_IDLE);
      rw_d    = (state_d == ST_WRITE) || (state_d == ST_CLEAR);
      oe_d    = (state_d == ST_WRITE) || (state_d == ST_CLEAR);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
      addr_d  = accept ? bus.addr_in : addr_q;
      wdata_d = accept ? bus.wdata : wdata_q;
      cnt_d   = (state_q == ST_CLEAR) ? cnt_q + 1'b1 : '0;
      enc_bin = (state_d == ST_CLEAR) ? cnt_d : addr_d;
      dout_d  = (state_d == ST_CLEAR) ? CLR_VALUE : wdata_d;
   end

   ram_bus_ctrl_bin2gray_enc #(.WIDTH(ADDR_BITS)) u_enc (
      .bin  (enc_bin),
      .gray (enc_gray)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q          <= 1'b0;
         rw_q          <= 1'b0;
         oe_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cnt_q         <= '0;
         ram_address_q <= '0;
         dout_q        <= '0;
         rdata_q       <= '0;
      end else begin
         cs_q          <= cs_d;
         rw_q          <= rw_d;
         oe_q          <= oe_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
         ram_address_q <= enc_gray;
         dout_q        <= dout_d;
         if (state_q == ST_RD_HOLD) rdata_q <= ram_data;
      end
   end

   assign ram_data        = oe_q ? dout_q : 'z;
   assign bus.ram_cs      = cs_q;
   assign bus.ram_rw      = rw_q;
   assign bus.ram_address = ram_address_q;
   assign bus.data_oe     = oe_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.rdata       = rdata_q;
   assign bus.state       = state_q;

endmodule

// File: doc/ram_bus_ctrl.md
Name: ram_bus_ctrl

Overview:
- Synchronous bus master that sits directly upstream of the 8x8 gray-addressed RAM and owns its CS/RW/ADDRESS/DATA pins.
- Turns a simple REQ/DONE command interface (binary address, write data, read data) into correctly timed RAM cycles. It converts binary to gray and manages the shared tri-state DATA bus.
- Provides a CLR command that writes CLR_VALUE into all 8 locations in one burst.

Parameters:
DATA_BITS, 8, width of RAM data bus and WDATA/RDATA
ADDR_BITS, 3, address width; RAM depth = 2**ADDR_BITS
CLR_VALUE, 0, value written to every location by CLR

Ports:
CLK  input  1  system clock, all state changes on posedge
RST  input  1  asynchronous, active-high reset
REQ  input  1  single-access request, sampled only in IDLE
WR  input  1  with REQ: 1 = write, 0 = read
ADDR_IN  input  ADDR_BITS  binary address for REQ
WDATA  input  DATA_BITS  write data for REQ
CLR  input  1  clear-all request, sampled only in IDLE
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle pulse when a command completes
RDATA  output  DATA_BITS  last read data, held until next read completes
RAM_CS  output  1  RAM chip select
RAM_RW  output  1  RAM mode, 1 = RAM stores DATA, 0 = RAM drives DATA
RAM_ADDRESS  output  ADDR_BITS  gray-coded RAM address
RAM_DATA  inout  DATA_BITS  shared data bus to RAM

Behaviour:
- Clock/reset: one clock, CLK; reset RST is asynchronous and active-high.
- Outputs driven from registers; the RAM_DATA output enable is a registered signal, high only in WRITE and CLEAR states.
- Reset values:
  - state=IDLE, RAM_CS=0, RAM_RW=0, RAM_ADDRESS=0.
  - RAM_DATA released (Z), RDATA=0, BUSY=0, DONE=0, clear counter=0.
- RST asserted mid-command: all of the above take effect immediately (asynchronous). The command is abandoned; no DONE is issued.
- Gray encode: RAM_ADDRESS = b ^ (b >> 1), where b is the binary address.
- States: IDLE, WRITE, RD_ADDR, RD_HOLD, CLEAR.
- IDLE:
  - Outputs: RAM_CS=0, RAM_RW=0, bus Z.
  - On an edge with CLR=1: go to CLEAR, counter=0.
  - Else with REQ=1: latch ADDR_IN and WDATA, go to WRITE if WR=1, else RD_ADDR.
  - CLR has priority over REQ; a simultaneous REQ is dropped.
- WRITE (1 cycle):
  - Outputs: RAM_CS=1, RAM_RW=1, gray(latched addr), RAM_DATA driven with latched WDATA.
  - The RAM stores the data at the exit edge.
  - Next state IDLE, with DONE=1 for that first IDLE cycle.
  - Latency: DONE rises 2 edges after the accepting edge.
- RD_ADDR (1 cycle): RAM_CS=1, RAM_RW=0, gray address, bus Z. The RAM loads its output register at the exit edge.
- RD_HOLD (1 cycle):
  - Same outputs as RD_ADDR; the RAM drives valid data.
  - At the exit edge: RDATA <= RAM_DATA, next state IDLE, DONE=1.
  - Latency: DONE and RDATA valid 3 edges after accept.
- CLEAR (2**ADDR_BITS cycles):
  - Outputs: RAM_CS=1, RAM_RW=1, RAM_ADDRESS=gray(counter), RAM_DATA=CLR_VALUE.
  - Counter increments each edge.
  - After the cycle with counter = max: IDLE, DONE=1.
  - No wrap or repeat.
- Bus turnaround: every command returns through IDLE (RAM_CS=0, bus Z), so a read is always followed by at least one cycle with no driver before any write. No cycle may have both RAM_CS&&!RAM_RW and the controller output enable high.
- REQ or CLR while BUSY: ignored, not queued. Requesters hold REQ until they see DONE and must then drop it.
- REQ held high across DONE: the cycle with DONE=1 is IDLE, so a new command is accepted on that edge (back-to-back allowed).
- RDATA is unchanged by writes and CLR.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, WRITE, RD_ADDR, RD_HOLD, CLEAR);
  - DATA_BITS/ADDR_BITS defaults;
  - a bin2gray function shared with any gray decoder elsewhere.
- Sub-module: bin2gray_enc, combinational, ADDR_BITS-parameterised. Used on both the latched-address and clear-counter paths via a mux.
- Everything else stays in one FSM module.

Test Plan:
- Write 8'hA5 to addr 3:
  - the WRITE cycle shows RAM_CS=1, RAM_RW=1, RAM_ADDRESS=3'b010, RAM_DATA=A5;
  - DONE pulses 2 edges after accept;
  - BUSY high exactly 1 cycle.
- After that write, read addr 3 with a RAM model attached:
  - RAM_RW=0 and bus not driven by the controller for 2 cycles;
  - RDATA=8'hA5 with DONE 3 edges after accept.
- CLR pulse:
  - 8 consecutive write cycles with RAM_ADDRESS 000,001,011,010,110,111,101,100 and RAM_DATA=00;
  - DONE after the 8th;
  - reads of addrs 0 and 7 then return 8'h00.
- CLR and REQ(WR=1, addr 5) on the same edge: CLEAR runs and no write of WDATA occurs. REQ asserted during the CLR burst is ignored; BUSY stays 1.
- RST asserted asynchronously in the 4th CLEAR cycle: RAM_CS=0, RAM_DATA=Z, BUSY=0 before the next edge, and no DONE. After release, a read of addr 0 completes normally.
- Back-to-back: read addr 1, then REQ held high for a write to addr 1. An IDLE cycle with RAM_CS=0 separates them, and there is no bus contention (checker asserts no double drive).
